imem_dump_reader: RTL and testbench

- Read-back counterpart of the instruction-memory load path (write_enable_fm / write_addr_fm / write_data_fm).
- Takes a base address and a word count, then issues sequential reads on the instruction memory's synchronous read port.
- Streams each word, with its address, out through a valid/ready interface to a debug or scoreboard sink.
- Used to confirm that the loaded program matches what was written, with the processor held in reset.

---
 rtl/imem_dump_reader.sv | 163 ++++++++++++++++
 tb/tb_imem_dump_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dump_reader.sv
// Instruction-memory read-back engine: walks an address range on the synchronous
// read port and streams {addr, data, last} beats to a valid/ready sink.
module imem_dump_reader #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, FIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } entry_t;

    state_t                      state_q, state_d;
    logic [ADDR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            remaining_q, remaining_d;
    logic                        inflight_q, inflight_d;
    logic [ADDR_W-1:0]           inf_addr_q, inf_addr_d;
    logic                        inf_last_q, inf_last_d;
    entry_t [FIFO_DEPTH-1:0]     fifo_q, fifo_d;
    logic                        wr_idx_q, wr_idx_d;
    logic                        rd_idx_q, rd_idx_d;
    logic [1:0]                  count_q, count_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;

    logic                        accept;
    logic                        issue;
    logic                        pop;
    logic                        drained;
    logic [1:0]                  occ;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_q[rd_idx_q].data;
    assign out_addr  = fifo_q[rd_idx_q].addr;
    assign out_last  = fifo_q[rd_idx_q].last;
    assign busy      = busy_q;
    assign done      = done_q;

    assign pop     = out_valid & out_ready;
    assign occ     = count_q + 2'(inflight_q);
    // done_q marks the cycle after FIN, which still counts as busy
    assign accept  = (state_q == IDLE) & start & ~done_q;
    assign drained = ~inflight_q & ((count_q == 2'd0) | ((count_q == 2'd1) & pop));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (word_count != '0) ? READ : FIN;
            READ:    if (issue && (remaining_q == CNT_W'(1))) state_d = FLUSH;
            FLUSH:   if (drained) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read issue: credit counts buffered plus in-flight words, a same-cycle pop frees one
    always_comb begin
        issue       = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        if ((state_q == READ) && (remaining_q != '0) &&
            ((occ < 2'(FIFO_DEPTH)) || pop)) begin
            issue       = 1'b1;
            mem_rd_en   = 1'b1;
            mem_rd_addr = rd_ptr_q;
        end
    end

    // Pointer, in-flight tracking and FIFO update
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        inf_addr_d  = inf_addr_q;
        inf_last_d  = inf_last_q;
        fifo_d      = fifo_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q + 2'(inflight_q) - 2'(pop);
        done_d      = (state_q == FIN);
        busy_d      = (state_d != IDLE) || (state_q == FIN);

        if (accept) begin
            rd_ptr_d    = base_addr;
            remaining_d = word_count;
        end else if (issue) begin
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            remaining_d = remaining_q - CNT_W'(1);
            inf_addr_d  = rd_ptr_q;
            inf_last_d  = (remaining_q == CNT_W'(1));
        end

        if (inflight_q) begin
            fifo_d[wr_idx_q].data = mem_rd_data;
            fifo_d[wr_idx_q].addr = inf_addr_q;
            fifo_d[wr_idx_q].last = inf_last_q;
            wr_idx_d              = ~wr_idx_q;
        end
        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            inf_addr_q  <= '0;
            inf_last_q  <= 1'b0;
            fifo_q      <= '0;
            wr_idx_q    <= 1'b0;
            rd_idx_q    <= 1'b0;
            count_q     <= 2'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            inf_addr_q  <= inf_addr_d;
            inf_last_q  <= inf_last_d;
            fifo_q      <= fifo_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_imem_dump_reader.sv
// Directed bench for imem_dump_reader: synchronous memory model, per-cycle beat
// collector and hand-computed expected streams.
module tb_imem_dump_reader;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    int total;
    int bad;

    logic [ADDR_W-1:0] b_addr[$];
    logic [DATA_W-1:0] b_data[$];
    logic              b_last[$];
    int                b_cyc[$];
    logic [ADDR_W-1:0] rd_addrs[$];
    logic [ADDR_W-1:0] e_addr[$];
    logic [DATA_W-1:0] e_data[$];

    int issued, popped, max_occ, valid_cnt, busy_cnt, done_cnt, done_cyc, first_rd;
    logic              stall_prev;
    logic [DATA_W-1:0] stall_data;
    logic [ADDR_W-1:0] stall_addr;

    imem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
        case (a)
            32'h20:  return 16'h095F;
            32'h21:  return 16'h975F;
            32'h22:  return 16'h639F;
            32'h23:  return 16'h1F3D;
            default: return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    // Instruction memory with one-cycle synchronous read
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mem_rd_data <= '0;
        else if (mem_rd_en) mem_rd_data <= word_at(mem_rd_addr);
    end

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c < 4) return (c == 0) || (c == 3);
        return (c % 2) == 1;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int c);
        int occ_now;
        occ_now = issued - popped;
        if (occ_now > max_occ) max_occ = occ_now;
        if (stall_prev && out_valid) begin
            check_val("stall_data", 64'(out_data), 64'(stall_data));
            check_val("stall_addr", 64'(out_addr), 64'(stall_addr));
        end
        if (mem_rd_en) begin
            rd_addrs.push_back(mem_rd_addr);
            issued++;
            if (first_rd < 0) first_rd = c;
        end
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready) begin
            b_addr.push_back(out_addr);
            b_data.push_back(out_data);
            b_last.push_back(out_last);
            b_cyc.push_back(c);
            popped++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = c;
        end
        if (busy) busy_cnt++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_addr = out_addr;
    endtask

    task automatic cycle(input logic st, input logic rdy, input int c);
        @(posedge clk);
        #1;
        start     = st;
        out_ready = rdy;
        @(negedge clk);
        sample(c);
    endtask

    task automatic clear_mon();
        b_addr.delete(); b_data.delete(); b_last.delete(); b_cyc.delete(); rd_addrs.delete();
        issued = 0; popped = 0; max_occ = 0; valid_cnt = 0; busy_cnt = 0;
        done_cnt = 0; done_cyc = -1; first_rd = -1; stall_prev = 1'b0;
    endtask

    task automatic set_exp(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        e_addr.delete();
        e_data.delete();
        for (int i = 0; i < n; i++) begin
            a = base + ADDR_W'(i);
            e_addr.push_back(a);
            e_data.push_back(word_at(a));
        end
    endtask

    task automatic run_dump(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt,
                            input int mode, input logic inject);
        logic st;
        clear_mon();
        base_addr  = base;
        word_count = cnt;
        for (int c = 0; c < 80; c++) begin
            st = (c == 0);
            if (inject && c == 2) begin
                st         = 1'b1;
                base_addr  = 32'h40;
                word_count = 16'd4;
            end
            cycle(st, ready_for(mode, c), c);
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = e_addr.size();
        check_val({tag, "_beats"}, 64'(b_addr.size()), 64'(n));
        check_val({tag, "_reads"}, 64'(rd_addrs.size()), 64'(n));
        check_val({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        for (int i = 0; i < n; i++) begin
            if (i < b_addr.size()) begin
                check_val($sformatf("%s_addr%0d", tag, i), 64'(b_addr[i]), 64'(e_addr[i]));
                check_val($sformatf("%s_data%0d", tag, i), 64'(b_data[i]), 64'(e_data[i]));
                check_val($sformatf("%s_last%0d", tag, i), 64'(b_last[i]), 64'(i == n - 1));
            end
            if (i < rd_addrs.size())
                check_val($sformatf("%s_rdaddr%0d", tag, i), 64'(rd_addrs[i]), 64'(e_addr[i]));
        end
        if (b_cyc.size() > 0)
            check_val({tag, "_done_after_last"}, 64'(done_cyc > b_cyc[b_cyc.size()-1]), 64'd1);
        check_val({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ctl"}, 64'({busy, done, mem_rd_en, out_valid, out_last}), 64'd0);
        check_val({tag, "_rdaddr"}, 64'(mem_rd_addr), 64'd0);
        check_val({tag, "_odata"}, 64'(out_data), 64'd0);
        check_val({tag, "_oaddr"}, 64'(out_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        clear_mon();
        #12;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic dump at full rate
        set_exp(32'h20, 4);
        run_dump(32'h20, 16'd4, 0, 1'b0);
        check_stream("basic");
        check_val("basic_first_rd", 64'(first_rd), 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < b_cyc.size()) check_val($sformatf("basic_cyc%0d", i), 64'(b_cyc[i]), 64'(3 + i));

        // Backpressure with ready 1,0,0,1,0,1...
        run_dump(32'h20, 16'd4, 1, 1'b0);
        check_stream("bp");
        check_val("bp_occ_over2", 64'(max_occ > 2), 64'd0);

        // Zero count
        run_dump(32'h100, 16'd0, 0, 1'b0);
        check_val("zero_reads", 64'(issued), 64'd0);
        check_val("zero_valid", 64'(valid_cnt), 64'd0);
        check_val("zero_done_cnt", 64'(done_cnt), 64'd1);
        check_val("zero_done_cyc", 64'(done_cyc), 64'd2);
        check_val("zero_busy_cycles", 64'(busy_cnt), 64'd2);

        // Address wrap-around
        set_exp(32'hFFFF_FFFE, 3);
        run_dump(32'hFFFF_FFFE, 16'd3, 0, 1'b0);
        check_stream("wrap");
        if (b_data.size() == 3) begin
            check_val("wrap_hand_d0", 64'(b_data[0]), 64'h A5A4);
            check_val("wrap_hand_d2", 64'(b_data[2]), 64'h 5A5A);
            check_val("wrap_hand_a2", 64'(b_addr[2]), 64'h0);
        end

        // start while busy is ignored
        set_exp(32'h20, 4);
        run_dump(32'h20, 16'd4, 0, 1'b1);
        check_stream("busy_start");

        // Asynchronous reset in the middle of an 8-word dump
        clear_mon();
        base_addr  = 32'h20;
        word_count = 16'd8;
        for (int c = 0; c < 40; c++) begin
            cycle(c == 0, 1'b1, c);
            if (b_addr.size() == 2) break;
        end
        check_val("mid_beats_before_rst", 64'(b_addr.size()), 64'd2);
        check_val("mid_valid_before_rst", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("mid_rst");
        start      = 1'b1;
        base_addr  = 32'h80;
        word_count = 16'd4;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_start_busy", 64'({busy, mem_rd_en, out_valid}), 64'd0);

        set_exp(32'h20, 2);
        run_dump(32'h20, 16'd2, 0, 1'b0);
        check_stream("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
